// File: rtl/control_pipe_pkg.sv
// Shared types for the decode/control stage: instruction word, ALU operations,
// decoded control bundle, FSM states and the canonical NOP.
package control_pipe_pkg;

    typedef logic [31:0] instruction_t;
    typedef logic [3:0]  cnt_t;

    typedef enum logic [4:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_SLT,
        ALU_SLTU,
        ALU_MUL,
        ALU_MULH,
        ALU_DIV,
        ALU_DIVU,
        ALU_REM,
        ALU_REMU
    } alu_op_t;

    typedef enum logic {
        IDLE,
        WAIT
    } ctrl_state_t;

    typedef struct packed {
        alu_op_t    alu_op;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       is_branch;
        logic       is_jump;
        logic       use_pc;
        logic       is_lui;
        logic [2:0] funct3;
        logic [4:0] rs1_id;
        logic [4:0] rs2_id;
        logic [4:0] write_back_id;
    } control_t;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam control_t NOP_CONTROL = '{
        alu_op:        ALU_ADD,
        alu_src:       1'b1,
        mem_read:      1'b0,
        mem_write:     1'b0,
        mem_to_reg:    1'b0,
        reg_write:     1'b0,
        is_branch:     1'b0,
        is_jump:       1'b0,
        use_pc:        1'b0,
        is_lui:        1'b0,
        funct3:        3'd0,
        rs1_id:        5'd0,
        rs2_id:        5'd0,
        write_back_id: 5'd0
    };

    function automatic logic is_multicycle(input alu_op_t op);
        return op inside {ALU_MUL, ALU_MULH, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    endfunction

    function automatic logic is_mul(input alu_op_t op);
        return op inside {ALU_MUL, ALU_MULH};
    endfunction

endpackage

// File: rtl/control_pipe_decode.sv
// Combinational RV32I(+M) decoder: instruction word -> control bundle and an
// illegal flag; illegal or disabled encodings collapse to the canonical NOP.
module control_decode
    import control_pipe_pkg::*;
#(
    parameter int ENABLE_M = 1
) (
    input  instruction_t instruction,
    output control_t     control,
    output logic         illegal
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    control_t   ctrl;
    logic       ill;

    assign opcode = instruction[6:0];
    assign f3     = instruction[14:12];
    assign f7     = instruction[31:25];

    always_comb begin
        ctrl               = NOP_CONTROL;
        ill                = 1'b0;
        ctrl.alu_src       = 1'b0;
        ctrl.funct3        = f3;
        ctrl.write_back_id = instruction[11:7];
        case (opcode)
            OPC_LOAD: begin
                ill             = !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
                ctrl.rs1_id     = instruction[19:15];
                ctrl.alu_src    = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            OPC_STORE: begin
                ill            = !(f3 inside {3'b000, 3'b001, 3'b010});
                ctrl.rs1_id    = instruction[19:15];
                ctrl.rs2_id    = instruction[24:20];
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            OPC_BRANCH: begin
                ctrl.rs1_id    = instruction[19:15];
                ctrl.rs2_id    = instruction[24:20];
                ctrl.is_branch = 1'b1;
                // f3[0] only inverts the sense of the compare, so it is left to execute.
                case (f3[2:1])
                    2'b00:   ctrl.alu_op = ALU_SUB;
                    2'b10:   ctrl.alu_op = ALU_SLT;
                    2'b11:   ctrl.alu_op = ALU_SLTU;
                    default: ill = 1'b1;
                endcase
            end
            OPC_LUI: begin
                ctrl.alu_src   = 1'b1;
                ctrl.is_lui    = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                ctrl.alu_src   = 1'b1;
                ctrl.use_pc    = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            OPC_JAL: begin
                ctrl.alu_src   = 1'b1;
                ctrl.use_pc    = 1'b1;
                ctrl.is_jump   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            OPC_JALR: begin
                ill            = (f3 != 3'b000);
                ctrl.rs1_id    = instruction[19:15];
                ctrl.alu_src   = 1'b1;
                ctrl.is_jump   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            OPC_OP_IMM: begin
                ctrl.rs1_id    = instruction[19:15];
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                case (f3)
                    3'b000:  ctrl.alu_op = ALU_ADD;
                    3'b010:  ctrl.alu_op = ALU_SLT;
                    3'b011:  ctrl.alu_op = ALU_SLTU;
                    3'b100:  ctrl.alu_op = ALU_XOR;
                    3'b110:  ctrl.alu_op = ALU_OR;
                    3'b111:  ctrl.alu_op = ALU_AND;
                    3'b001: begin
                        ctrl.alu_op = ALU_SLL;
                        ill         = (f7 != F7_BASE);
                    end
                    default: begin
                        ctrl.alu_op = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                        ill         = !(f7 inside {F7_BASE, F7_ALT});
                    end
                endcase
            end
            OPC_OP: begin
                ctrl.rs1_id    = instruction[19:15];
                ctrl.rs2_id    = instruction[24:20];
                ctrl.reg_write = 1'b1;
                if (f7 == F7_BASE) begin
                    case (f3)
                        3'b000:  ctrl.alu_op = ALU_ADD;
                        3'b001:  ctrl.alu_op = ALU_SLL;
                        3'b010:  ctrl.alu_op = ALU_SLT;
                        3'b011:  ctrl.alu_op = ALU_SLTU;
                        3'b100:  ctrl.alu_op = ALU_XOR;
                        3'b101:  ctrl.alu_op = ALU_SRL;
                        3'b110:  ctrl.alu_op = ALU_OR;
                        default: ctrl.alu_op = ALU_AND;
                    endcase
                end else if (f7 == F7_ALT) begin
                    case (f3)
                        3'b000:  ctrl.alu_op = ALU_SUB;
                        3'b101:  ctrl.alu_op = ALU_SRA;
                        default: ill = 1'b1;
                    endcase
                end else if (f7 == F7_MULDIV && ENABLE_M != 0) begin
                    // MULHSU/MULHU share the high-product op; funct3 tells them apart.
                    case (f3)
                        3'b000:  ctrl.alu_op = ALU_MUL;
                        3'b001,
                        3'b010,
                        3'b011:  ctrl.alu_op = ALU_MULH;
                        3'b100:  ctrl.alu_op = ALU_DIV;
                        3'b101:  ctrl.alu_op = ALU_DIVU;
                        3'b110:  ctrl.alu_op = ALU_REM;
                        default: ctrl.alu_op = ALU_REMU;
                    endcase
                end else begin
                    ill = 1'b1;
                end
            end
            OPC_MISC_MEM: begin
                ctrl = NOP_CONTROL;
            end
            default: begin
                ill = 1'b1;
            end
        endcase
        if (ill) begin
            ctrl = NOP_CONTROL;
        end
    end

    assign control = ctrl;
    assign illegal = ill;

endmodule

// File: rtl/control_pipe.sv
// Registered decode/control stage: one instruction per handshake, output held
// until consumed, issue stalled while a MUL/DIV latency counter runs.
module control_pipe
    import control_pipe_pkg::*;
#(
    parameter int ENABLE_M    = 1,
    parameter int MUL_LATENCY = 3,
    parameter int DIV_LATENCY = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  instruction_t instruction,
    output logic         out_valid,
    input  logic         out_ready,
    output control_t     control,
    output logic         busy,
    output logic         illegal
);

    localparam cnt_t MUL_LAT = cnt_t'(MUL_LATENCY);
    localparam cnt_t DIV_LAT = cnt_t'(DIV_LATENCY);

    ctrl_state_t state_q, state_d;
    cnt_t        cnt_q, cnt_d;
    logic        out_valid_q, out_valid_d;
    logic        busy_q, busy_d;
    logic        illegal_q, illegal_d;
    control_t    control_q, control_d;

    control_t    dec_control;
    logic        dec_illegal;
    logic        accept;
    cnt_t        lat;

    control_decode #(
        .ENABLE_M (ENABLE_M)
    ) u_decode (
        .instruction (instruction),
        .control     (dec_control),
        .illegal     (dec_illegal)
    );

    assign in_ready = !flush && (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign lat      = is_mul(dec_control.alu_op) ? MUL_LAT : DIV_LAT;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        illegal_d   = 1'b0;
        control_d   = control_q;
        if (flush) begin
            state_d     = IDLE;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (out_valid_q && out_ready) begin
                        out_valid_d = 1'b0;
                    end
                    if (accept) begin
                        control_d = dec_control;
                        illegal_d = dec_illegal;
                        cnt_d     = lat - cnt_t'(1);
                        // A latency of 1 behaves exactly like a single-cycle op.
                        if (is_multicycle(dec_control.alu_op) && lat > cnt_t'(1)) begin
                            out_valid_d = 1'b0;
                            busy_d      = 1'b1;
                            state_d     = WAIT;
                        end else begin
                            cnt_d       = '0;
                            out_valid_d = 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == cnt_t'(1)) begin
                        cnt_d       = '0;
                        out_valid_d = 1'b1;
                        busy_d      = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        cnt_d = cnt_q - cnt_t'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            illegal_q   <= 1'b0;
            control_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            illegal_q   <= illegal_d;
            control_q   <= control_d;
        end
    end

    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign illegal   = illegal_q;
    assign control   = control_q;

endmodule
